axi_write_arbiter: RTL and testbench

Two-master, one-slave arbiter for the AXI write path (AW, W and B channels). It grants the shared slave to one master for a whole write transaction: address, all data beats, then the write response. Grants rotate round-robin between transactions. It sits between the bench-side masters and the write ports of the duv slave.

---
 rtl/axi_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// ============================================================================
// Module   : axi_write_arbiter
// Brief    : Two-master / one-slave round-robin arbiter for the AXI write path
//            (AW, W, B). One master owns the slave for a whole transaction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic                      CLOCK,
  input  logic                      RESET,

  // Master-side AW channel (master i in slice i)
  input  logic [1:0]                M_AWVALID,
  output logic [1:0]                M_AWREADY,
  input  logic [2*WIDTH-1:0]        M_AWADDR,
  input  logic [2*(WIDTH/8)-1:0]    M_AWID,
  input  logic [2*(WIDTH/8)-1:0]    M_AWLEN,
  input  logic [2*SIZE-1:0]         M_AWSIZE,
  input  logic [2*(SIZE-1)-1:0]     M_AWBURST,

  // Master-side W channel
  input  logic [1:0]                M_WVALID,
  output logic [1:0]                M_WREADY,
  input  logic [1:0]                M_WLAST,
  input  logic [2*WIDTH-1:0]        M_WDATA,
  input  logic [2*(WIDTH/8)-1:0]    M_WSTRB,
  input  logic [2*(WIDTH/8)-1:0]    M_WID,

  // Master-side B channel
  output logic [1:0]                M_BVALID,
  input  logic [1:0]                M_BREADY,
  output logic [2*(WIDTH/8)-1:0]    M_BID,
  output logic [2*(SIZE-1)-1:0]     M_BRESP,

  // Slave-side AW channel
  output logic                      S_AWVALID,
  input  logic                      S_AWREADY,
  output logic [WIDTH-1:0]          S_AWADDR,
  output logic [WIDTH/8-1:0]        S_AWID,
  output logic [WIDTH/8-1:0]        S_AWLEN,
  output logic [SIZE-1:0]           S_AWSIZE,
  output logic [SIZE-2:0]           S_AWBURST,

  // Slave-side W channel
  output logic                      S_WVALID,
  input  logic                      S_WREADY,
  output logic                      S_WLAST,
  output logic [WIDTH-1:0]          S_WDATA,
  output logic [WIDTH/8-1:0]        S_WSTRB,
  output logic [WIDTH/8-1:0]        S_WID,

  // Slave-side B channel
  input  logic                      S_BVALID,
  output logic                      S_BREADY,
  input  logic [WIDTH/8-1:0]        S_BID,
  input  logic [SIZE-2:0]           S_BRESP,

  // Status
  output logic [1:0]                GRANT,
  output logic                      PROTO_ERR
);

  localparam int IW = WIDTH / 8;
  localparam int BW = SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_ptr;
  logic [3:0]  r_cnt;
  logic [3:0]  r_len;
  logic        r_proto_err;

  logic        w_sel;
  logic        w_own;
  logic        w_in_addr;
  logic        w_in_data;
  logic        w_in_resp;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_b_fire;
  logic        w_final;
  logic [3:0]  w_awlen4;

  assign w_sel     = r_grant[1];
  assign w_own     = |r_grant;
  assign w_in_addr = (r_state == ST_ADDR);
  assign w_in_data = (r_state == ST_DATA);
  assign w_in_resp = (r_state == ST_RESP);

  // Payload follows the owner; with no owner the slave sees all-zero payload
  assign S_AWADDR  = !w_own ? '0 : (w_sel ? M_AWADDR[2*WIDTH-1:WIDTH] : M_AWADDR[WIDTH-1:0]);
  assign S_AWID    = !w_own ? '0 : (w_sel ? M_AWID[2*IW-1:IW]         : M_AWID[IW-1:0]);
  assign S_AWLEN   = !w_own ? '0 : (w_sel ? M_AWLEN[2*IW-1:IW]        : M_AWLEN[IW-1:0]);
  assign S_AWSIZE  = !w_own ? '0 : (w_sel ? M_AWSIZE[2*SIZE-1:SIZE]   : M_AWSIZE[SIZE-1:0]);
  assign S_AWBURST = !w_own ? '0 : (w_sel ? M_AWBURST[2*BW-1:BW]      : M_AWBURST[BW-1:0]);
  assign S_WDATA   = !w_own ? '0 : (w_sel ? M_WDATA[2*WIDTH-1:WIDTH]  : M_WDATA[WIDTH-1:0]);
  assign S_WSTRB   = !w_own ? '0 : (w_sel ? M_WSTRB[2*IW-1:IW]        : M_WSTRB[IW-1:0]);
  assign S_WID     = !w_own ? '0 : (w_sel ? M_WID[2*IW-1:IW]          : M_WID[IW-1:0]);

  assign S_AWVALID = w_in_addr & M_AWVALID[w_sel];
  assign S_WVALID  = w_in_data & M_WVALID[w_sel];
  assign S_WLAST   = w_in_data & M_WLAST[w_sel];
  assign S_BREADY  = w_in_resp & M_BREADY[w_sel];

  // GRANT is one-hot, so masking with it steers the ready/valid to the owner only
  assign M_AWREADY = {2{w_in_addr & S_AWREADY}} & r_grant;
  assign M_WREADY  = {2{w_in_data & S_WREADY}}  & r_grant;
  assign M_BVALID  = {2{w_in_resp & S_BVALID}}  & r_grant;

  assign M_BID     = {2{S_BID}};
  assign M_BRESP   = {2{S_BRESP}};

  assign w_aw_fire = S_AWVALID & S_AWREADY;
  assign w_w_fire  = S_WVALID & S_WREADY;
  assign w_b_fire  = S_BVALID & S_BREADY;
  assign w_final   = (r_cnt == r_len);

  generate
    if (IW >= 4) begin : g_len_wide
      assign w_awlen4 = S_AWLEN[3:0];
    end else begin : g_len_narrow
      assign w_awlen4 = {{(4-IW){1'b0}}, S_AWLEN};
    end
  endgenerate

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_grant     <= 2'b00;
      r_ptr       <= 1'b0;
      r_cnt       <= 4'd0;
      r_len       <= 4'd0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|M_AWVALID) begin
            r_state <= ST_ADDR;
            if (&M_AWVALID) r_grant <= r_ptr ? 2'b10 : 2'b01;
            else            r_grant <= M_AWVALID;
          end
        end
        ST_ADDR: begin
          if (w_aw_fire) begin
            r_len   <= w_awlen4;
            r_cnt   <= 4'd0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The beat count, not WLAST, decides where the burst ends
          if (w_w_fire) begin
            if (S_WLAST != w_final) r_proto_err <= 1'b1;
            if (w_final) r_state <= ST_RESP;
            else         r_cnt   <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (w_b_fire) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_ptr   <= ~w_sel;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign GRANT     = r_grant;
  assign PROTO_ERR = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
// ============================================================================
// Module   : tb_axi_write_arbiter
// Brief    : Table-driven and directed self-checking bench for axi_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_write_arbiter;

  localparam int WIDTH = 32;
  localparam int SIZE  = 3;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  M_AWVALID, M_AWREADY;
  logic [63:0] M_AWADDR;
  logic [7:0]  M_AWID, M_AWLEN;
  logic [5:0]  M_AWSIZE;
  logic [3:0]  M_AWBURST;
  logic [1:0]  M_WVALID, M_WREADY, M_WLAST;
  logic [63:0] M_WDATA;
  logic [7:0]  M_WSTRB, M_WID;
  logic [1:0]  M_BVALID, M_BREADY;
  logic [7:0]  M_BID;
  logic [3:0]  M_BRESP;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_AWADDR;
  logic [3:0]  S_AWID, S_AWLEN;
  logic [2:0]  S_AWSIZE;
  logic [1:0]  S_AWBURST;
  logic        S_WVALID, S_WREADY, S_WLAST;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB, S_WID;
  logic        S_BVALID, S_BREADY;
  logic [3:0]  S_BID;
  logic [1:0]  S_BRESP;
  logic [1:0]  GRANT;
  logic        PROTO_ERR;

  axi_write_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWID(M_AWID),
    .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WLAST(M_WLAST), .M_WDATA(M_WDATA),
    .M_WSTRB(M_WSTRB), .M_WID(M_WID),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWID(S_AWID),
    .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WLAST(S_WLAST), .S_WDATA(S_WDATA),
    .S_WSTRB(S_WSTRB), .S_WID(S_WID),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
    .GRANT(GRANT), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int n_assert = 0;
  int n_fail   = 0;

  // One cycle-vector: inputs applied after a falling edge, outputs checked 1 ns later
  typedef struct packed {
    logic        rst_n;
    logic [1:0]  awv, wv, wl, br;
    logic        sawr, swr, sbv;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLOCK);
  endtask

  // Observation word: {GRANT, S_AWVALID, S_WVALID, S_WLAST, S_BREADY, M_AWREADY, M_WREADY, M_BVALID, PROTO_ERR}
  function automatic logic [13:0] obs();
    return {GRANT, S_AWVALID, S_WVALID, S_WLAST, S_BREADY, M_AWREADY, M_WREADY, M_BVALID, PROTO_ERR};
  endfunction

  function automatic logic [13:0] ex(input logic [1:0] g, input logic saw, input logic sw, input logic swl,
                                     input logic sbr, input logic [1:0] mawr, input logic [1:0] mwr,
                                     input logic [1:0] mbv, input logic perr);
    return {g, saw, sw, swl, sbr, mawr, mwr, mbv, perr};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic [1:0] awv, input logic [1:0] wv,
                              input logic [1:0] wl, input logic [1:0] br, input logic sawr,
                              input logic swr, input logic sbv, input logic [13:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.awv = awv; v.wv = wv; v.wl = wl; v.br = br;
    v.sawr = sawr; v.swr = swr; v.sbv = sbv; v.exp = exp;
    return v;
  endfunction

  task automatic idle_inputs();
    M_AWVALID = 2'b00; M_WVALID = 2'b00; M_WLAST = 2'b00; M_BREADY = 2'b00;
    S_AWREADY = 1'b0;  S_WREADY = 1'b0;  S_BVALID = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    cyc();
    RESET = 1'b1;
  endtask

  initial begin
    logic [13:0] z;
    logic [31:0] pat [2];
    logic [31:0] got [$];
    int beat, stall, early, cy;
    bit aw_done, b_done;

    z = '0;
    pat[0] = 32'hA5A5_A5A5;
    pat[1] = 32'h5A5A_5A5A;

    M_AWADDR  = {32'h0000_0200, 32'h0000_0100};
    M_AWID    = {4'h2, 4'h1};
    M_AWLEN   = {4'd1, 4'd3};
    M_AWSIZE  = {3'd2, 3'd2};
    M_AWBURST = {2'b01, 2'b01};
    M_WDATA   = {32'h1111_1111, 32'h0000_0000};
    M_WSTRB   = 8'hFF;
    M_WID     = {4'h2, 4'h1};
    S_BID     = 4'h3;
    S_BRESP   = 2'b00;
    idle_inputs();

    // Master 0 alone, LEN=3, slave always ready
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, z));
    vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, z));
    vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b01, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 1, ex(2'b01, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 1, z));
    // Both request after reset: master 0 first, then master 1 (LEN=1)
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, z));
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, z));
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b10, 2'b11, 2'b01, 2'b00, 1, 1, 0, ex(2'b01, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 2'b11, 1, 1, 1, ex(2'b01, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0)));
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, z));
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0, ex(2'b10, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 0, ex(2'b10, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b10, 2'b00, 1, 1, 0, ex(2'b10, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b10, 1, 1, 1, ex(2'b10, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0)));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, z));

    for (int i = 0; i < vecs.size(); i++) begin
      RESET = vecs[i].rst_n; M_AWVALID = vecs[i].awv; M_WVALID = vecs[i].wv;
      M_WLAST = vecs[i].wl;  M_BREADY = vecs[i].br;   S_AWREADY = vecs[i].sawr;
      S_WREADY = vecs[i].swr; S_BVALID = vecs[i].sbv;
      #1;
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
      if (i == 2)  chk("aw_addr_m0", S_AWADDR, 32'h100);
      if (i == 7)  chk("bid_bresp_m0", {M_BID, M_BRESP}, {8'h33, 4'h0});
      if (i == 18) chk("aw_len_m1", S_AWLEN, 4'd1);
      if (i == 19) chk("wid_m1", S_WID, 4'h2);
      cyc();
    end

    // Slave backpressure on master 1, LEN=1
    do_reset();
    beat = 0; stall = 0; early = 0; cy = 0; aw_done = 0; b_done = 0;
    while (!b_done && cy < 40) begin
      M_AWVALID = aw_done ? 2'b00 : 2'b10;
      S_AWREADY = (cy >= 4);
      S_WREADY  = cy[0];
      M_WVALID  = (beat < 2) ? 2'b10 : 2'b00;
      M_WDATA   = {(beat < 2) ? pat[beat] : 32'h0, 32'hDEAD_BEEF};
      M_WLAST   = (beat == 1) ? 2'b10 : 2'b00;
      S_BVALID  = (beat == 2);
      M_BREADY  = 2'b10;
      #1;
      if (S_AWVALID && !S_AWREADY) stall++;
      if (S_WVALID && S_WREADY) begin
        if (!aw_done) early++;
        got.push_back(S_WDATA);
        beat++;
      end
      if (M_AWVALID[1] && M_AWREADY[1]) aw_done = 1;
      if (M_BVALID[1] && M_BREADY[1]) b_done = 1;
      cyc();
      cy++;
    end
    idle_inputs();
    #1;
    chk("bp_b_done", b_done, 1);
    chk("bp_aw_stall_cycles", stall, 3);
    chk("bp_early_beats", early, 0);
    chk("bp_beat_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("bp_wdata0", got[0], 32'hA5A5_A5A5);
      chk("bp_wdata1", got[1], 32'h5A5A_5A5A);
    end
    chk("bp_idle_after", {GRANT, PROTO_ERR}, 3'b000);
    cyc();

    // WLAST on beat 1 of a LEN=2 burst from master 0
    do_reset();
    M_AWLEN = {4'd1, 4'd2};
    beat = 0; cy = 0; aw_done = 0; b_done = 0;
    S_AWREADY = 1'b1; S_WREADY = 1'b1; M_BREADY = 2'b01;
    while (!b_done && cy < 30) begin
      M_AWVALID = aw_done ? 2'b00 : 2'b01;
      M_WVALID  = (beat < 3) ? 2'b01 : 2'b00;
      M_WLAST   = (beat == 1) ? 2'b01 : 2'b00;
      M_WDATA   = {32'h0, 32'(beat)};
      S_BVALID  = (beat == 3);
      #1;
      if (beat == 2 && S_WVALID) chk("perr_after_early_last", PROTO_ERR, 1);
      if (S_WVALID && S_WREADY) beat++;
      if (M_AWVALID[0] && M_AWREADY[0]) aw_done = 1;
      if (M_BVALID[0] && M_BREADY[0]) b_done = 1;
      cyc();
      cy++;
    end
    idle_inputs();
    chk("wl_b_done", b_done, 1);
    chk("wl_beat_count", beat, 3);
    cyc();
    #1;
    chk("perr_sticky_idle", {GRANT, PROTO_ERR}, 3'b001);

    // Reset in DATA after 2 of 4 beats (PROTO_ERR still set from above)
    M_AWLEN = {4'd1, 4'd3};
    M_AWVALID = 2'b01; S_AWREADY = 1'b1; S_WREADY = 1'b1;
    cyc();
    #1;
    chk("rst_seq_addr_valid", {GRANT, S_AWVALID}, 3'b011);
    cyc();
    M_AWVALID = 2'b00; M_WVALID = 2'b01; M_WLAST = 2'b00;
    #1;
    chk("rst_seq_beat0_ready", M_WREADY, 2'b01);
    cyc();
    cyc();
    RESET = 1'b0;
    cyc();
    RESET = 1'b1;
    M_AWVALID = 2'b10;
    #1;
    chk("post_reset_ctrl", obs(), 14'h0);
    chk("post_reset_payload", {S_WDATA, S_AWADDR}, 64'h0);
    cyc();
    #1;
    chk("m1_regrant", {GRANT, S_AWVALID, S_AWADDR}, {2'b10, 1'b1, 32'h200});
    chk("m1_early_w_stalled", {S_WVALID, M_WREADY}, 3'b000);
    cyc();
    M_AWVALID = 2'b00; M_WVALID = 2'b10; M_WLAST = 2'b00;
    #1;
    chk("m1_beat0_ready", M_WREADY, 2'b10);
    cyc();
    M_WLAST = 2'b10;
    cyc();
    M_WVALID = 2'b00; M_WLAST = 2'b00; S_BVALID = 1'b1; M_BREADY = 2'b10;
    #1;
    chk("m1_bvalid", M_BVALID, 2'b10);
    cyc();
    idle_inputs();
    #1;
    chk("m1_done_idle", {GRANT, PROTO_ERR}, 3'b000);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
